// File: rtl/shift_wb_buffer.sv
// Writeback-side result buffer for the shift unit: an in-order FIFO with a registered
// stall toward issue, a sticky overflow flag, and first-word fall-through output.
package shift_wb_pkg;
   localparam int WIDTH_DATA = 32;
   typedef logic [WIDTH_DATA-1:0] data_t;
   typedef struct packed {
      logic [1:0] opcode;
      logic [4:0] rd_addr;
   } pipe_exe_tmp_t;
endpackage

module shift_wb_buffer
   import shift_wb_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type TYPE  = pipe_exe_tmp_t
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     I_Valid,
   input  data_t                    I_Data,
   input  TYPE                      I_Token,
   output logic                     O_Stall,
   output logic                     O_Valid,
   output data_t                    O_Data,
   output TYPE                      O_Token,
   input  logic                     I_Ready,
   output logic [$clog2(DEPTH):0]   O_Count,
   output logic                     O_Overflow
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] STALL_AT = CNT_W'(DEPTH - 1);

   data_t            data_mem [DEPTH];
   TYPE              tok_mem  [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic             overflow_q;
   logic             stall_q;
   logic             push;
   logic             pop;
   logic             drop;

   // Handshake: the head transfers on any edge where O_Valid && I_Ready; O_Valid never
   // depends on I_Ready, and the producer side has no backpressure, only the stall hint.
   always_comb begin
      pop        = (count != '0) && I_Ready;
      push       = I_Valid && ((count != FULL) || pop);
      drop       = I_Valid && !push;
      count_next = count;
      if (push && !pop)
         count_next = count + CNT_W'(1);
      else if (pop && !push)
         count_next = count - CNT_W'(1);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow_q <= 1'b0;
         stall_q    <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count_next;
         if (drop)
            overflow_q <= 1'b1;
         // One free slot of slack absorbs the result issued while this stall registers.
         stall_q <= (count_next >= STALL_AT);
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         data_mem[wr_ptr] <= I_Data;
         tok_mem[wr_ptr]  <= I_Token;
      end
   end

   assign O_Valid    = (count != '0);
   assign O_Data     = O_Valid ? data_mem[rd_ptr] : '0;
   assign O_Token    = O_Valid ? tok_mem[rd_ptr] : '0;
   assign O_Count    = count;
   assign O_Overflow = overflow_q;
   assign O_Stall    = stall_q;
endmodule

// File: tb/tb_shift_wb_buffer.sv
// Directed bench for shift_wb_buffer: reset, pass-through, fill/stall, overflow,
// full simultaneous push/pop with pointer wrap, and reset during operation.
module tb_shift_wb_buffer;
   import shift_wb_pkg::*;

   logic          clock;
   logic          reset;
   logic          I_Valid;
   data_t         I_Data;
   pipe_exe_tmp_t I_Token;
   logic          O_Stall;
   logic          O_Valid;
   data_t         O_Data;
   pipe_exe_tmp_t O_Token;
   logic          I_Ready;
   logic [2:0]    O_Count;
   logic          O_Overflow;

   int n_checks = 0;
   int n_fail   = 0;

   shift_wb_buffer #(.DEPTH(4), .TYPE(pipe_exe_tmp_t)) dut (
      .clock      (clock),
      .reset      (reset),
      .I_Valid    (I_Valid),
      .I_Data     (I_Data),
      .I_Token    (I_Token),
      .O_Stall    (O_Stall),
      .O_Valid    (O_Valid),
      .O_Data     (O_Data),
      .O_Token    (O_Token),
      .I_Ready    (I_Ready),
      .O_Count    (O_Count),
      .O_Overflow (O_Overflow)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic pipe_exe_tmp_t mk_tok(input logic [1:0] op, input logic [4:0] rd);
      pipe_exe_tmp_t t;
      t.opcode  = op;
      t.rd_addr = rd;
      return t;
   endfunction

   task automatic test_reset();
      reset = 1'b0; I_Valid = 1'b0; I_Data = '0; I_Token = '0; I_Ready = 1'b0;
      tick(); tick();
      reset = 1'b1;
      n_checks++; if (O_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", O_Valid); end
      n_checks++; if (O_Data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", O_Data); end
      n_checks++; if (O_Token !== 7'h0) begin n_fail++; $display("FAIL reset_token: got %h want 0", O_Token); end
      n_checks++; if (O_Count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", O_Count); end
      n_checks++; if (O_Stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", O_Stall); end
      n_checks++; if (O_Overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", O_Overflow); end
      tick();
      n_checks++; if (O_Valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b want 0", O_Valid); end
   endtask

   task automatic test_pass_through();
      pipe_exe_tmp_t tok;
      tok = mk_tok(2'b10, 5'd3);
      I_Valid = 1'b1; I_Data = 32'h0000_00F0; I_Token = tok; I_Ready = 1'b1;
      n_checks++; if (O_Valid !== 1'b0) begin n_fail++; $display("FAIL pt_no_bypass: got %b want 0", O_Valid); end
      tick();
      I_Valid = 1'b0; I_Data = '0; I_Token = '0;
      n_checks++; if (O_Valid !== 1'b1) begin n_fail++; $display("FAIL pt_valid: got %b want 1", O_Valid); end
      n_checks++; if (O_Data !== 32'h0000_00F0) begin n_fail++; $display("FAIL pt_data: got %h want 000000f0", O_Data); end
      n_checks++; if (O_Token !== tok) begin n_fail++; $display("FAIL pt_token: got %h want %h", O_Token, tok); end
      n_checks++; if (O_Count !== 3'd1) begin n_fail++; $display("FAIL pt_count1: got %0d want 1", O_Count); end
      tick();
      I_Ready = 1'b0;
      n_checks++; if (O_Count !== 3'd0) begin n_fail++; $display("FAIL pt_count0: got %0d want 0", O_Count); end
      n_checks++; if (O_Valid !== 1'b0) begin n_fail++; $display("FAIL pt_empty: got %b want 0", O_Valid); end
      n_checks++; if (O_Data !== 32'h0) begin n_fail++; $display("FAIL pt_empty_data: got %h want 0", O_Data); end
   endtask

   // Leaves the buffer holding 1,2,3,4 with I_Ready low.
   task automatic test_fill_stall();
      logic [2:0] exp_count [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
      logic       exp_stall [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      I_Ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         I_Valid = 1'b1; I_Data = 32'(i + 1); I_Token = mk_tok(2'(i + 1), 5'(i + 1));
         tick();
         n_checks++; if (O_Count !== exp_count[i]) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, O_Count, exp_count[i]); end
         n_checks++; if (O_Stall !== exp_stall[i]) begin n_fail++; $display("FAIL fill_stall[%0d]: got %b want %b", i, O_Stall, exp_stall[i]); end
      end
      I_Valid = 1'b0; I_Data = '0; I_Token = '0;
      n_checks++; if (O_Data !== 32'd1) begin n_fail++; $display("FAIL fill_head: got %h want 1", O_Data); end
   endtask

   task automatic test_overflow_drain();
      logic [2:0] exp_count [4] = '{3'd3, 3'd2, 3'd1, 3'd0};
      logic       exp_stall [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
      I_Valid = 1'b1; I_Data = 32'd5; I_Token = mk_tok(2'd1, 5'd5); I_Ready = 1'b0;
      tick();
      I_Valid = 1'b0; I_Data = '0; I_Token = '0;
      n_checks++; if (O_Overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", O_Overflow); end
      n_checks++; if (O_Count !== 3'd4) begin n_fail++; $display("FAIL ovf_count: got %0d want 4", O_Count); end
      tick();
      n_checks++; if (O_Overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", O_Overflow); end
      I_Ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (O_Data !== 32'(i + 1)) begin n_fail++; $display("FAIL drain_data[%0d]: got %h want %h", i, O_Data, 32'(i + 1)); end
         n_checks++; if (O_Token !== mk_tok(2'(i + 1), 5'(i + 1))) begin n_fail++; $display("FAIL drain_token[%0d]: got %h want %h", i, O_Token, mk_tok(2'(i + 1), 5'(i + 1))); end
         tick();
         n_checks++; if (O_Count !== exp_count[i]) begin n_fail++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, O_Count, exp_count[i]); end
         n_checks++; if (O_Stall !== exp_stall[i]) begin n_fail++; $display("FAIL drain_stall[%0d]: got %b want %b", i, O_Stall, exp_stall[i]); end
      end
      I_Ready = 1'b0;
      n_checks++; if (O_Valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %b want 0 (dropped 5 leaked)", O_Valid); end
      n_checks++; if (O_Overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_after_drain: got %b want 1", O_Overflow); end
   endtask

   task automatic test_full_push_pop();
      data_t      exp_data  [4] = '{32'd2, 32'd3, 32'd4, 32'd9};
      logic [2:0] exp_count [4] = '{3'd3, 3'd2, 3'd1, 3'd0};
      reset = 1'b0; tick(); reset = 1'b1;
      n_checks++; if (O_Overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_ovf_clear: got %b want 0", O_Overflow); end
      test_fill_stall();
      I_Valid = 1'b1; I_Data = 32'd9; I_Token = mk_tok(2'd3, 5'd9); I_Ready = 1'b1;
      tick();
      I_Valid = 1'b0; I_Data = '0; I_Token = '0;
      n_checks++; if (O_Count !== 3'd4) begin n_fail++; $display("FAIL fpp_count: got %0d want 4", O_Count); end
      n_checks++; if (O_Overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_ovf: got %b want 0", O_Overflow); end
      n_checks++; if (O_Stall !== 1'b1) begin n_fail++; $display("FAIL fpp_stall: got %b want 1", O_Stall); end
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (O_Data !== exp_data[i]) begin n_fail++; $display("FAIL fpp_data[%0d]: got %h want %h", i, O_Data, exp_data[i]); end
         tick();
         n_checks++; if (O_Count !== exp_count[i]) begin n_fail++; $display("FAIL fpp_count[%0d]: got %0d want %0d", i, O_Count, exp_count[i]); end
      end
      n_checks++; if (O_Token !== 7'h0) begin n_fail++; $display("FAIL fpp_empty_token: got %h want 0", O_Token); end
      I_Ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      I_Ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         I_Valid = 1'b1; I_Data = 32'hA0 + 32'(i); I_Token = mk_tok(2'd1, 5'(i));
         tick();
      end
      n_checks++; if (O_Count !== 3'd3) begin n_fail++; $display("FAIL rm_pre_count: got %0d want 3", O_Count); end
      reset = 1'b0; I_Valid = 1'b1; I_Data = 32'hDEAD; I_Token = mk_tok(2'd2, 5'd7); I_Ready = 1'b1;
      tick();
      reset = 1'b1; I_Valid = 1'b0; I_Data = '0; I_Token = '0; I_Ready = 1'b0;
      n_checks++; if (O_Count !== 3'd0) begin n_fail++; $display("FAIL rm_count: got %0d want 0", O_Count); end
      n_checks++; if (O_Valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid: got %b want 0", O_Valid); end
      n_checks++; if (O_Stall !== 1'b0) begin n_fail++; $display("FAIL rm_stall: got %b want 0", O_Stall); end
      tick();
      n_checks++; if (O_Valid !== 1'b0) begin n_fail++; $display("FAIL rm_not_retained: got %b want 0", O_Valid); end
      I_Valid = 1'b1; I_Data = 32'h77; I_Token = mk_tok(2'd0, 5'd1);
      tick();
      I_Valid = 1'b0; I_Data = '0; I_Token = '0;
      n_checks++; if (O_Data !== 32'h77) begin n_fail++; $display("FAIL rm_fresh_head: got %h want 77", O_Data); end
      n_checks++; if (O_Count !== 3'd1) begin n_fail++; $display("FAIL rm_fresh_count: got %0d want 1", O_Count); end
   endtask

   initial begin
      test_reset();
      test_pass_through();
      test_fill_stall();
      test_overflow_drain();
      test_full_push_pop();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/shift_wb_buffer.md
Name: shift_wb_buffer

Overview:
- Receiving end of the shift unit's result interface (valid, data, token).
- Captures every result the shift unit emits and holds it in an in-order FIFO.
- Drains to the register-file writeback port through a valid/ready handshake.
- Raises a stall toward the issue stage. The shift unit is zero-latency and has no ready input, so the issue stage must stop enabling it while the buffer cannot accept a result.

Parameters:
- DEPTH, 4, number of result entries; power of two, minimum 2.
- TYPE, pipe_exe_tmp_t, token type carried alongside data (same type the shift unit forwards).

Ports:
- clock  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous active-low reset; state clears on a rising clock edge while reset==0.
- I_Valid  input  1  shift unit result valid.
- I_Data  input  WIDTH_DATA (data_t)  shift unit result data.
- I_Token  input  $bits(TYPE)  shift unit result token.
- O_Stall  output  1  to issue stage: do not assert shift unit enable this cycle.
- O_Valid  output  1  head entry present toward writeback.
- O_Data  output  WIDTH_DATA  head entry data; '0 when empty.
- O_Token  output  $bits(TYPE)  head entry token; '0 when empty.
- I_Ready  input  1  writeback accepts head this cycle.
- O_Count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- O_Overflow  output  1  sticky: a result arrived and was dropped.

Behaviour:
- Reset (reset==0 at an edge):
  - write/read pointers, count, overflow flag cleared to 0; entry storage need not clear.
  - Outputs after reset: O_Valid=0, O_Data='0, O_Token='0, O_Count=0, O_Overflow=0, O_Stall=0.
  - Reset mid-drain discards all entries; reset has priority over push and pop in the same cycle.
- Storage: circular buffer, pointers $clog2(DEPTH) bits, wrap from DEPTH-1 to 0. Count held separately to distinguish full from empty.
- Pop: fire = O_Valid && I_Ready.
  - Read pointer advances and count decrements at the edge.
  - I_Ready while empty has no effect.
- Push: accepted when I_Valid && (count<DEPTH || pop fire this cycle).
  - Data and token written at the write pointer; write pointer advances.
- Occupancy update:
  - push and pop together: count unchanged, both pointers advance.
  - push only: +1.
  - pop only: -1.
- Overflow: I_Valid while count==DEPTH and no pop this cycle.
  - Result dropped; pointers and count unchanged.
  - O_Overflow set next cycle; stays 1 until reset.
- Output (first-word fall-through):
  - O_Valid = (count!=0); O_Data/O_Token driven combinationally from the head entry, '0 when count==0.
  - A result pushed into an empty buffer appears on O_Valid the cycle after its push edge (1-cycle latency).
  - No bypass from I_* to O_*.
- Stall (registered):
  - O_Stall=1 when next-cycle count >= DEPTH-1, i.e. at most one free slot.
  - One slot of slack covers the result issued in the cycle the stall is being registered.
  - O_Stall=0 whenever next count <= DEPTH-2.
- Ordering: strict FIFO; tokens stay paired with their data.
- O_Count reflects registered count; updates on the edge following push/pop.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, release -> O_Valid=0, O_Data=0, O_Count=0, O_Stall=0, O_Overflow=0.
- Single pass-through: push data 32'h0000_00F0 with token opcode 2'b10, I_Ready=1 -> O_Valid=1 with that data/token exactly one cycle later; popped the same cycle; O_Count returns to 0.
- Fill and stall: I_Ready=0, push 4 results 1,2,3,4 on consecutive cycles ->
  - O_Stall rises after the 3rd push (count 3 = DEPTH-1).
  - O_Count=4 after the 4th push.
  - Raising I_Ready drains 1,2,3,4 in order; O_Stall falls once count <= 2.
- Overflow: with count=4 and I_Ready=0, push 5 -> dropped, O_Overflow=1 next cycle and stays 1; drain yields only 1,2,3,4.
- Full simultaneous push/pop: count=4, I_Ready=1, push 9 -> accepted, count stays 4, O_Overflow stays 0; the 9 emerges after 2,3,4, with pointer wrap exercised.
- Reset mid-operation: count=3, assert reset=0 with I_Valid=1 and I_Ready=1 -> count=0, O_Valid=0; the pushed value is not retained.
